// File: rtl/logic_issue.sv
// Issue buffer in front of the 32-bit logic unit: decodes MIPS32 logical ops into
// data_a/data_b/one-hot c/rd and holds them in a 2-entry skid buffer (main + skid).
module logic_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data_a,
  output logic [31:0] out_data_b,
  output logic [3:0]  out_c,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_unsup
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;

  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_AND = 4'b0010;
  localparam logic [3:0] C_XOR = 4'b1000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [4:0]  rd;
    logic        wen;
    logic        unsup;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_dec;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic        w_accept;
  logic        w_pop;
  logic        w_unused_rs_field;

  assign w_op    = in_instr[31:26];
  assign w_funct = in_instr[5:0];
  assign w_imm   = in_instr[15:0];
  // Register numbers for rs arrive already resolved in in_rs_val.
  assign w_unused_rs_field = ^in_instr[25:21];

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    w_dec       = '0;
    w_dec.unsup = 1'b1;
    case (w_op)
      OP_SPECIAL: begin
        if (w_funct == FN_AND || w_funct == FN_OR || w_funct == FN_XOR) begin
          w_dec.a     = in_rs_val;
          w_dec.b     = in_rt_val;
          w_dec.rd    = in_instr[15:11];
          w_dec.unsup = 1'b0;
          w_dec.c     = (w_funct == FN_AND) ? C_AND :
                        (w_funct == FN_OR)  ? C_OR  : C_XOR;
        end
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_dec.a     = in_rs_val;
        w_dec.b     = {16'h0000, w_imm};
        w_dec.rd    = in_instr[20:16];
        w_dec.unsup = 1'b0;
        w_dec.c     = (w_op == OP_ANDI) ? C_AND :
                      (w_op == OP_ORI)  ? C_OR  : C_XOR;
      end
      OP_LUI: begin
        // LUI runs through the unit as (imm << 16) | 0.
        w_dec.a     = {w_imm, 16'h0000};
        w_dec.b     = '0;
        w_dec.c     = C_OR;
        w_dec.rd    = in_instr[20:16];
        w_dec.unsup = 1'b0;
      end
      default: ;
    endcase
    w_dec.wen = !w_dec.unsup && (w_dec.rd != 5'd0);
  end

  assign in_ready  = (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: both data registers are reset because main drives the outputs, which must read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main  <= w_dec;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_pop) begin
            r_main <= w_dec;
          end else if (w_accept) begin
            r_skid  <= w_dec;
            r_state <= S_TWO;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_main  <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign out_data_a = r_main.a;
  assign out_data_b = r_main.b;
  assign out_c      = r_main.c;
  assign out_rd     = r_main.rd;
  assign out_wen    = r_main.wen;
  assign out_unsup  = r_main.unsup;

endmodule
